traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
//  Sequences the two-road intersection light: alternates green between road A and road B with an all-red clearance between them.
//  Sizes each green phase from queue lengths (numOfCarsA/B) and rushHourWarning from the time-of-day clock.
//  Drives greenForA/greenForB/remainingTime for IntersectionSimulator.
//  One clk cycle = one simulated second, same time base as the clock/calendar logic.
// PARAMETERS
//  NORMAL_GREEN  50  base green length in seconds, rush hour off
//  RUSH_GREEN    70  base green length in seconds, rush hour on
//  EXTEND        20  bonus seconds when the served road's queue dominates
//  IMBALANCE     5   dominance threshold: served > other + IMBALANCE
//  MAX_GREEN     99  cap on loaded green length; all green params 1..99
//  CLEAR_TIME    3   all-red clearance length, 1..15
//  GAP_TIME      5   gap-out truncation target, 1..MAX_GREEN
// PORTS
//  clk              in   1  system clock, rising edge, 1 cycle = 1 s
//  reset            in   1  synchronous, active-high
//  rushHourWarning  in   1  from time-of-day block
//  numOfCarsA       in   5  current queue length, road A
//  numOfCarsB       in   5  current queue length, road B
//  freeze           in   1  hold countdown and state (display/edit modes)
//  greenForA        out  1  road A green
//  greenForB        out  1  road B green
//  remainingTime    out  7  seconds left in current phase, 1..99
//  phaseStart       out  1  one-cycle pulse on the first cycle of each green
// BEHAVIOUR
//  - Registers: phase state, 7-bit countdown. All outputs are registered; no combinational input->output path.
//  - Reset (sync, wins over everything): state=GREEN_A; remainingTime=NORMAL_GREEN; greenForA=1; greenForB=0; phaseStart=1.
//    Queue lengths and rush are not used at reset.
//  - FSM: GREEN_A -> CLEAR_AB -> GREEN_B -> CLEAR_BA -> GREEN_A.
//    greenForA=1 only in GREEN_A; greenForB=1 only in GREEN_B.
//    Both lights are 0 in CLEAR_*. Both lights at 1 is never legal.
//  - Countdown: a phase of length N shows N, N-1, ..., 1 on N consecutive cycles.
//    On the cycle after it shows 1, the next phase is entered with its loaded length.
//  - Clearance load: remainingTime = CLEAR_TIME.
//  - Green load: on entry to GREEN_X, served = cars X, other = cars Y, both sampled on the transition edge.
//    len = rushHourWarning ? RUSH_GREEN : NORMAL_GREEN.
//    If served > other + IMBALANCE, len += EXTEND.
//    Then len = min(len, MAX_GREEN).
//    Compare in 6 bits; add in 8 bits; no wrap.
//  - Rush and queue changes mid-phase never extend a running phase.
//  - Gap-out: in GREEN_X with served==0, other!=0 and remainingTime>GAP_TIME, the next value is GAP_TIME, not remaining-1.
//    Gap-out can only shorten a phase. It has no effect in CLEAR_* or when remainingTime<=GAP_TIME.
//  - freeze=1: state, remainingTime and lights hold; phaseStart=0; gap-out is suppressed.
//    A transition due on a frozen cycle occurs on the first unfrozen cycle.
//  - phaseStart=1 on the first cycle of each GREEN_*; 0 otherwise.
//  - Priority: reset > freeze > gap-out > normal decrement/transition.
// STRUCTURE
//  - Shared package traffic_pkg: phase_t enum {GREEN_A, CLEAR_AB, GREEN_B, CLEAR_BA}; CAR_W=5; TIME_W=7.
//  - Sub-module green_len_calc (combinational): takes served, other, rush and returns len with the cap applied.
//    It is instantiated once, with its inputs muxed by the target road.
//  - The top level holds the FSM and countdown only.
// TESTING
//  1. Reset, cars 0/0, rush 0, default params
//     -> A green, remaining 50..1; then both lights 0, remaining 3..1; then B green, remaining 50, phaseStart pulses.
//  2. Entering GREEN_B with carsB=12, carsA=3, rush=1
//     -> remaining loads 90 (70+20); carsB=8, carsA=3 -> loads 70.
//  3. MAX_GREEN=80, rush=1, carsA=20, carsB=0, entering GREEN_A -> remaining loads 80.
//  4. GREEN_A at remaining 40, set carsA=0, carsB=4 -> next cycle 5, then 4..1, then CLEAR_AB.
//     Repeat at remaining 3 -> normal decrement.
//  5. freeze=1 for 10 cycles at GREEN_B remaining 1 -> outputs held.
//     After release, CLEAR_BA entered next cycle; freeze in CLEAR holds all-red.
//  6. reset asserted mid GREEN_B (remaining 30) -> next cycle GREEN_A, remaining 50, greenForB=0.
//     Check every cycle: !(greenForA && greenForB).

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and widths for the intersection light scheduler.
//   phase_t      - light phase sequence GREEN_A -> CLEAR_AB -> GREEN_B -> CLEAR_BA
//   CAR_W        - width of a road queue length
//   TIME_W       - width of the phase countdown (seconds)
//   green_req_t  - inputs to the green length calculation for the road being served
package traffic_pkg;

    localparam int CAR_W  = 5;
    localparam int TIME_W = 7;

    typedef enum logic [1:0] {
        GREEN_A  = 2'd0,
        CLEAR_AB = 2'd1,
        GREEN_B  = 2'd2,
        CLEAR_BA = 2'd3
    } phase_t;

    typedef struct packed {
        logic [CAR_W-1:0] served;
        logic [CAR_W-1:0] other;
        logic             rush;
    } green_req_t;

endpackage

// File: rtl/green_len_calc.sv
// green_len_calc: combinational green phase length for the road about to be served.
//   req  in   served queue, opposing queue, rush-hour flag
//   len  out  base green (rush or normal), plus EXTEND when the served queue
//             dominates, capped at MAX_GREEN
module green_len_calc
    import traffic_pkg::*;
#(
    parameter int NORMAL_GREEN = 50,
    parameter int RUSH_GREEN   = 70,
    parameter int EXTEND       = 20,
    parameter int IMBALANCE    = 5,
    parameter int MAX_GREEN    = 99
) (
    input  green_req_t        req,
    output logic [TIME_W-1:0] len
);

    // Threshold fits in 6 bits (31 + IMBALANCE); the sum fits in 8 bits
    // (99 + 99), so neither step can wrap.
    logic [5:0] thr;
    logic [7:0] base;
    logic [7:0] sum;

    always_comb begin
        thr  = {1'b0, req.other} + 6'(IMBALANCE);
        base = req.rush ? 8'(RUSH_GREEN) : 8'(NORMAL_GREEN);
        sum  = ({1'b0, req.served} > thr) ? base + 8'(EXTEND) : base;
        len  = (sum > 8'(MAX_GREEN)) ? TIME_W'(MAX_GREEN) : sum[TIME_W-1:0];
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: two-road intersection light sequencer, 1 clk = 1 s.
//   clk, reset        clock and synchronous active-high reset
//   rushHourWarning   selects the longer base green
//   numOfCarsA/B      queue lengths, sampled on entry to a green and for gap-out
//   freeze            holds state and countdown, suppresses phaseStart and gap-out
//   greenForA/B       registered lights, never both set
//   remainingTime     registered seconds left in the current phase (N..1)
//   phaseStart        one-cycle pulse on the first cycle of each green
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int NORMAL_GREEN = 50,
    parameter int RUSH_GREEN   = 70,
    parameter int EXTEND       = 20,
    parameter int IMBALANCE    = 5,
    parameter int MAX_GREEN    = 99,
    parameter int CLEAR_TIME   = 3,
    parameter int GAP_TIME     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rushHourWarning,
    input  logic [CAR_W-1:0]  numOfCarsA,
    input  logic [CAR_W-1:0]  numOfCarsB,
    input  logic              freeze,
    output logic              greenForA,
    output logic              greenForB,
    output logic [TIME_W-1:0] remainingTime,
    output logic              phaseStart
);

    phase_t             state;
    green_req_t         req;
    logic [TIME_W-1:0]  green_len;
    logic [CAR_W-1:0]   served_now;
    logic [CAR_W-1:0]   other_now;
    logic               in_green;
    logic               gap_out;

    // The length is only consumed when leaving a clearance, so the mux
    // selects the road that the clearance leads into.
    always_comb begin
        req.rush = rushHourWarning;
        if (state == CLEAR_AB) begin
            req.served = numOfCarsB;
            req.other  = numOfCarsA;
        end else begin
            req.served = numOfCarsA;
            req.other  = numOfCarsB;
        end
    end

    green_len_calc #(
        .NORMAL_GREEN (NORMAL_GREEN),
        .RUSH_GREEN   (RUSH_GREEN),
        .EXTEND       (EXTEND),
        .IMBALANCE    (IMBALANCE),
        .MAX_GREEN    (MAX_GREEN)
    ) u_len (
        .req (req),
        .len (green_len)
    );

    // Empty served road with waiting traffic opposite: cut the green short.
    always_comb begin
        in_green   = (state == GREEN_A) || (state == GREEN_B);
        served_now = (state == GREEN_B) ? numOfCarsB : numOfCarsA;
        other_now  = (state == GREEN_B) ? numOfCarsA : numOfCarsB;
        gap_out    = in_green && (served_now == '0) && (other_now != '0) &&
                     (remainingTime > TIME_W'(GAP_TIME));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= GREEN_A;
            remainingTime <= TIME_W'(NORMAL_GREEN);
            greenForA     <= 1'b1;
            greenForB     <= 1'b0;
            phaseStart    <= 1'b1;
        end else if (freeze) begin
            phaseStart <= 1'b0;
        end else if (gap_out) begin
            remainingTime <= TIME_W'(GAP_TIME);
            phaseStart    <= 1'b0;
        end else if (remainingTime <= TIME_W'(1)) begin
            case (state)
                GREEN_A: begin
                    state         <= CLEAR_AB;
                    remainingTime <= TIME_W'(CLEAR_TIME);
                    greenForA     <= 1'b0;
                    greenForB     <= 1'b0;
                    phaseStart    <= 1'b0;
                end
                CLEAR_AB: begin
                    state         <= GREEN_B;
                    remainingTime <= green_len;
                    greenForA     <= 1'b0;
                    greenForB     <= 1'b1;
                    phaseStart    <= 1'b1;
                end
                GREEN_B: begin
                    state         <= CLEAR_BA;
                    remainingTime <= TIME_W'(CLEAR_TIME);
                    greenForA     <= 1'b0;
                    greenForB     <= 1'b0;
                    phaseStart    <= 1'b0;
                end
                default: begin
                    state         <= GREEN_A;
                    remainingTime <= green_len;
                    greenForA     <= 1'b1;
                    greenForB     <= 1'b0;
                    phaseStart    <= 1'b1;
                end
            endcase
        end else begin
            remainingTime <= remainingTime - TIME_W'(1);
            phaseStart    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: stimulus pushes the expected post-edge outputs into a
// queue, monitors pop and compare on the falling edge.
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, rush, freeze;
    logic [CAR_W-1:0]  carsA, carsB;
    logic              gA, gB, ps;
    logic [TIME_W-1:0] rem;

    // Second instance with a lowered cap, exercising the MAX_GREEN clamp.
    logic              reset2;
    logic [CAR_W-1:0]  carsA2, carsB2;
    logic              gA2, gB2, ps2;
    logic [TIME_W-1:0] rem2;

    traffic_phase_scheduler dut (
        .clk(clk), .reset(reset), .rushHourWarning(rush),
        .numOfCarsA(carsA), .numOfCarsB(carsB), .freeze(freeze),
        .greenForA(gA), .greenForB(gB), .remainingTime(rem), .phaseStart(ps)
    );

    traffic_phase_scheduler #(.MAX_GREEN(80)) dut80 (
        .clk(clk), .reset(reset2), .rushHourWarning(1'b1),
        .numOfCarsA(carsA2), .numOfCarsB(carsB2), .freeze(1'b0),
        .greenForA(gA2), .greenForB(gB2), .remainingTime(rem2), .phaseStart(ps2)
    );

    typedef struct packed {
        logic        ga;
        logic        gb;
        logic [6:0]  rem;
        logic        ps;
        logic [7:0]  tag;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic step(input logic ga, input logic gb, input int r, input logic p, input int tag);
        exp_t e;
        e.ga = ga; e.gb = gb; e.rem = 7'(r); e.ps = p; e.tag = 8'(tag);
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic count(input logic ga, input logic gb, input int from, input int to, input int tag);
        for (int v = from; v >= to; v--) step(ga, gb, v, 1'b0, tag);
    endtask

    // Main monitor: one expected entry per clock, plus the lights invariant.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (gA && gB) begin
            failures++;
            $display("FAIL both_green t=%0t gA=%0b gB=%0b", $time, gA, gB);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({gA, gB, rem, ps} !== {e.ga, e.gb, e.rem, e.ps}) begin
                failures++;
                $display("FAIL test%0d t=%0t got gA=%0b gB=%0b rem=%0d ps=%0b exp gA=%0b gB=%0b rem=%0d ps=%0b",
                         e.tag, $time, gA, gB, rem, ps, e.ga, e.gb, e.rem, e.ps);
            end
        end
    end

    // Capped instance monitor: compares the load at each green start.
    always @(negedge clk) begin
        exp_t e;
        if (ps2 && q2.size() > 0) begin
            e = q2.pop_front();
            checks++;
            if ({gA2, gB2, rem2} !== {e.ga, e.gb, e.rem}) begin
                failures++;
                $display("FAIL cap_load t=%0t got gA=%0b gB=%0b rem=%0d exp gA=%0b gB=%0b rem=%0d",
                         $time, gA2, gB2, rem2, e.ga, e.gb, e.rem);
            end
        end
    end

    // Capped instance: reset load 50, B entry 70 (then gap-out), A entry 70+20 capped to 80.
    initial begin
        exp_t e;
        reset2 = 1'b1; carsA2 = 5'd20; carsB2 = 5'd0;
        e = '0; e.ga = 1'b1; e.rem = 7'd50; q2.push_back(e);
        e = '0; e.gb = 1'b1; e.rem = 7'd70; q2.push_back(e);
        e = '0; e.ga = 1'b1; e.rem = 7'd80; q2.push_back(e);
        @(posedge clk); #1;
        reset2 = 1'b0;
    end

    initial begin
        // 1: reset and default cycle
        reset = 1'b1; rush = 1'b0; freeze = 1'b0; carsA = 5'd0; carsB = 5'd0;
        step(1, 0, 50, 1, 1);
        reset = 1'b0;
        count(1, 0, 49, 1, 1);
        count(0, 0, 3, 1, 1);
        step(0, 1, 50, 1, 1);
        count(0, 1, 49, 1, 1);
        count(0, 0, 3, 1, 1);
        step(1, 0, 50, 1, 1);

        // 2: rush with dominant queue extends; non-dominant does not
        rush = 1'b1; carsA = 5'd3; carsB = 5'd12;
        count(1, 0, 49, 1, 2);
        count(0, 0, 3, 1, 2);
        step(0, 1, 90, 1, 2);
        carsA = 5'd8; carsB = 5'd3;
        count(0, 1, 89, 1, 2);
        count(0, 0, 3, 1, 2);
        step(1, 0, 70, 1, 2);

        // 4: gap-out at 40 jumps to 5; at 3 it is a plain decrement
        count(1, 0, 69, 40, 4);
        carsA = 5'd0; carsB = 5'd4;
        step(1, 0, 5, 0, 4);
        count(1, 0, 4, 1, 4);
        rush = 1'b0;
        count(0, 0, 3, 1, 4);
        step(0, 1, 50, 1, 4);
        count(0, 1, 49, 3, 4);
        carsA = 5'd4; carsB = 5'd0;
        count(0, 1, 2, 1, 4);
        count(0, 0, 3, 1, 4);
        step(1, 0, 50, 1, 4);

        // 5: freeze suppresses gap-out, holds at remaining 1, holds all-red
        carsA = 5'd0; carsB = 5'd4; freeze = 1'b1;
        step(1, 0, 50, 0, 5);
        step(1, 0, 50, 0, 5);
        freeze = 1'b0;
        step(1, 0, 5, 0, 5);
        count(1, 0, 4, 1, 5);
        carsA = 5'd0; carsB = 5'd0;
        count(0, 0, 3, 1, 5);
        step(0, 1, 50, 1, 5);
        count(0, 1, 49, 1, 5);
        freeze = 1'b1;
        repeat (10) step(0, 1, 1, 0, 5);
        freeze = 1'b0;
        step(0, 0, 3, 0, 5);
        freeze = 1'b1;
        repeat (3) step(0, 0, 3, 0, 5);
        freeze = 1'b0;
        count(0, 0, 2, 1, 5);
        step(1, 0, 50, 1, 5);

        // 6: reset mid GREEN_B
        count(1, 0, 49, 1, 6);
        count(0, 0, 3, 1, 6);
        step(0, 1, 50, 1, 6);
        count(0, 1, 49, 30, 6);
        reset = 1'b1;
        step(1, 0, 50, 1, 6);
        reset = 1'b0;
        count(1, 0, 49, 45, 6);

        @(negedge clk); #1;
        checks++;
        if (q.size() != 0 || q2.size() != 0) begin
            failures++;
            $display("FAIL queues_drained main_left=%0d cap_left=%0d exp 0", q.size(), q2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
